// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the NxN matrix multiply-accumulate block:
//   - state encodings and the state enum (IDLE / CALC / DONE)
//   - clog2(): index and accumulator width helper, usable in constant
//     expressions (parameter and localparam declarations)
// -----------------------------------------------------------------------------
package matmul_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CALC_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    CALC = ST_CALC_ENC,
    DONE = ST_DONE_ENC
  } state_e;

  // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
  function automatic int clog2(input int value);
    int w;
    w = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Registered unsigned multiply-add with synchronous clear.
//   acc <= clr ? 0 : en ? (first ? 0 : acc) + a*b : acc
// 'first' restarts the running sum with the current product so a new dot
// product can begin on the same edge the previous one is retired.
// Ports:
//   clk   in   clock, rising edge
//   clr   in   synchronous clear of the accumulator (highest priority)
//   en    in   perform one multiply-accumulate this edge
//   first in   discard the previous sum (start of a new dot product)
//   a, b  in   ENTRY_SIZE-bit unsigned operands
//   acc   out  ACC_SIZE-bit registered running sum
// -----------------------------------------------------------------------------
module mac_unit #(
  parameter int ENTRY_SIZE = 5,
  parameter int ACC_SIZE   = 12
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  first,
  input  logic [ENTRY_SIZE-1:0] a,
  input  logic [ENTRY_SIZE-1:0] b,
  output logic [ACC_SIZE-1:0]   acc
);

  logic [2*ENTRY_SIZE-1:0] prod_s;
  logic [ACC_SIZE-1:0]     base_s;
  logic [ACC_SIZE-1:0]     acc_r;

  // Full-width product and the sum it is added onto.
  always_comb begin
    prod_s = (2*ENTRY_SIZE)'(a) * (2*ENTRY_SIZE)'(b);
    if (first) begin
      base_s = {ACC_SIZE{1'b0}};
    end else begin
      base_s = acc_r;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_r <= {ACC_SIZE{1'b0}};
    end else if (en) begin
      acc_r <= base_s + ACC_SIZE'(prod_s);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/matrix_mac_nxn.sv
// -----------------------------------------------------------------------------
// matrix_mac_nxn
// Unsigned NxN matrix multiply C = A * B using a single multiply-accumulate
// unit, one MAC per cycle, k innermost, then j, then i.
// Optional feature: define MATMUL_SAT_EN to saturate each result entry to
// 2^RESENTRY_SIZE-1; otherwise entries are the sum modulo 2^RESENTRY_SIZE.
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   synchronous, active-high reset
//   start    in   request a multiply (only sampled in IDLE)
//   matrixA  in   A row-major, A[0][0] in the MSBs
//   matrixB  in   B column-wise: slot [j][k] holds B[k][j], slot [0][0] in MSBs
//   busy     out  high while calculating
//   done     out  one-cycle pulse, matrixC valid
//   matrixC  out  C row-major, C[0][0] in the MSBs; held until next start
// Timing: start accepted on edge 0 -> N^3 MAC edges -> the last sum is
// retired into matrixC on edge N^3+1, which is also the edge entering DONE.
// -----------------------------------------------------------------------------
module matrix_mac_nxn
  import matmul_pkg::*;
#(
  parameter int N             = 3,
  parameter int ENTRY_SIZE    = 5,
  parameter int RESENTRY_SIZE = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N*N*ENTRY_SIZE-1:0]     matrixA,
  input  logic [N*N*ENTRY_SIZE-1:0]     matrixB,
  output logic                          busy,
  output logic                          done,
  output logic [N*N*RESENTRY_SIZE-1:0]  matrixC
);

  localparam int IW       = clog2(N);
  localparam int ACC_SIZE = 2*ENTRY_SIZE + clog2(N);
  localparam int XW       = (ACC_SIZE > RESENTRY_SIZE) ? ACC_SIZE : RESENTRY_SIZE;

  localparam logic [IW-1:0] ZERO_IDX = {IW{1'b0}};
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e state_r;
  state_e state_nxt_s;

  logic [IW-1:0] i_r;
  logic [IW-1:0] j_r;
  logic [IW-1:0] k_r;
  logic [IW-1:0] wr_i_r;
  logic [IW-1:0] wr_j_r;
  logic          wr_pend_r;   // acc holds a finished C[wr_i][wr_j]
  logic          drain_r;     // all MACs issued, last sum still to retire

  logic [N*N*ENTRY_SIZE-1:0] a_cap_r;
  logic [N*N*ENTRY_SIZE-1:0] b_cap_r;

  logic [ENTRY_SIZE-1:0]    a_ent_s [N][N];
  logic [ENTRY_SIZE-1:0]    b_ent_s [N][N];
  logic [RESENTRY_SIZE-1:0] c_mat_r [N][N];

  logic [ENTRY_SIZE-1:0] op_a_s;
  logic [ENTRY_SIZE-1:0] op_b_s;
  logic [ACC_SIZE-1:0]   acc_s;
  logic                  mac_en_s;
  logic                  mac_first_s;
  logic                  mac_clr_s;

  logic busy_nxt_s;
  logic done_nxt_s;
  logic busy_r;
  logic done_r;

  // Reduce a finished dot product to the result entry width.
  function automatic logic [RESENTRY_SIZE-1:0] reduce_sum(input logic [ACC_SIZE-1:0] sum);
    logic [XW-1:0] wide;
    wide = XW'(sum);
`ifdef MATMUL_SAT_EN
    if (wide > XW'({RESENTRY_SIZE{1'b1}})) begin
      return {RESENTRY_SIZE{1'b1}};
    end else begin
      return wide[RESENTRY_SIZE-1:0];
    end
`else
    return wide[RESENTRY_SIZE-1:0];
`endif
  endfunction

  // Unpack captured operands and pack the result array (index 0 in the MSBs).
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign a_ent_s[r][c] = a_cap_r[((N*N-1)-(r*N+c))*ENTRY_SIZE +: ENTRY_SIZE];
      assign b_ent_s[r][c] = b_cap_r[((N*N-1)-(r*N+c))*ENTRY_SIZE +: ENTRY_SIZE];
      assign matrixC[((N*N-1)-(r*N+c))*RESENTRY_SIZE +: RESENTRY_SIZE] = c_mat_r[r][c];
    end
  end

  // Operand select: A[i][k] and B[k][j] (stored in slot [j][k]).
  assign op_a_s = a_ent_s[i_r][k_r];
  assign op_b_s = b_ent_s[j_r][k_r];

  mac_unit #(
    .ENTRY_SIZE (ENTRY_SIZE),
    .ACC_SIZE   (ACC_SIZE)
  ) u_mac (
    .clk   (clk),
    .clr   (mac_clr_s),
    .en    (mac_en_s),
    .first (mac_first_s),
    .a     (op_a_s),
    .b     (op_b_s),
    .acc   (acc_s)
  );

  // MAC control: accumulate while issuing, hold the accumulator cleared otherwise.
  always_comb begin
    mac_en_s    = 1'b0;
    mac_clr_s   = 1'b1;
    mac_first_s = (k_r == ZERO_IDX);
    if (reset) begin
      mac_en_s  = 1'b0;
      mac_clr_s = 1'b1;
    end else if ((state_r == CALC) && !drain_r) begin
      mac_en_s  = 1'b1;
      mac_clr_s = 1'b0;
    end else begin
      mac_en_s  = 1'b0;
      mac_clr_s = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (drain_r) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
      CALC: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b0;
      end
      DONE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;

  // Operand capture, loop counters and result write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_cap_r   <= {(N*N*ENTRY_SIZE){1'b0}};
      b_cap_r   <= {(N*N*ENTRY_SIZE){1'b0}};
      i_r       <= ZERO_IDX;
      j_r       <= ZERO_IDX;
      k_r       <= ZERO_IDX;
      wr_i_r    <= ZERO_IDX;
      wr_j_r    <= ZERO_IDX;
      wr_pend_r <= 1'b0;
      drain_r   <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          c_mat_r[r][c] <= {RESENTRY_SIZE{1'b0}};
        end
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_cap_r   <= matrixA;
            b_cap_r   <= matrixB;
            i_r       <= ZERO_IDX;
            j_r       <= ZERO_IDX;
            k_r       <= ZERO_IDX;
            wr_pend_r <= 1'b0;
            drain_r   <= 1'b0;
          end else begin
            drain_r   <= 1'b0;
          end
        end
        CALC: begin
          // The sum completed on the previous edge is retired now, while the
          // MAC restarts on the next element via 'first'.
          if (wr_pend_r) begin
            c_mat_r[wr_i_r][wr_j_r] <= reduce_sum(acc_s);
          end else begin
            c_mat_r[wr_i_r][wr_j_r] <= c_mat_r[wr_i_r][wr_j_r];
          end
          if (!drain_r) begin
            wr_pend_r <= (k_r == LAST_IDX);
            wr_i_r    <= i_r;
            wr_j_r    <= j_r;
            if (k_r != LAST_IDX) begin
              k_r <= k_r + ONE_IDX;
            end else begin
              k_r <= ZERO_IDX;
              if (j_r != LAST_IDX) begin
                j_r <= j_r + ONE_IDX;
              end else begin
                j_r <= ZERO_IDX;
                if (i_r != LAST_IDX) begin
                  i_r <= i_r + ONE_IDX;
                end else begin
                  i_r     <= ZERO_IDX;
                  drain_r <= 1'b1;
                end
              end
            end
          end else begin
            wr_pend_r <= 1'b0;
            drain_r   <= 1'b0;
          end
        end
        DONE: begin
          wr_pend_r <= 1'b0;
        end
        default: begin
          wr_pend_r <= 1'b0;
          drain_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mac_nxn.sv
// Self-checking bench for matrix_mac_nxn: table of vectors with a result
// scoreboard, plus sequences for restart, reset abort and back-to-back runs.
module tb_matrix_mac_nxn;

  localparam int N  = 3;
  localparam int E  = 5;
  localparam int R  = 9;
  localparam int AW = N*N*E;
  localparam int CW = N*N*R;
  localparam int LAT = N*N*N + 1;

  localparam int N2  = 2;
  localparam int E2  = 4;
  localparam int R2  = 9;

`ifdef MATMUL_SAT_EN
  localparam int EXP31 = 511;
`else
  localparam int EXP31 = 323;
`endif

  typedef int mat_t [3][3];
  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [CW-1:0] c;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] matrixA;
  logic [AW-1:0] matrixB;
  logic          busy;
  logic          done;
  logic [CW-1:0] matrixC;

  logic                start2;
  logic [N2*N2*E2-1:0] matrixA2;
  logic [N2*N2*E2-1:0] matrixB2;
  logic                busy2;
  logic                done2;
  logic [N2*N2*R2-1:0] matrixC2;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int done_cnt  = 0;

  logic [CW-1:0]       sb  [$];
  logic [N2*N2*R2-1:0] sb2 [$];

  vec_t tbl [5];

  always #5 clk = ~clk;

  matrix_mac_nxn #(.N(N), .ENTRY_SIZE(E), .RESENTRY_SIZE(R)) u_dut (
    .clk(clk), .reset(reset), .start(start), .matrixA(matrixA), .matrixB(matrixB),
    .busy(busy), .done(done), .matrixC(matrixC));

  matrix_mac_nxn #(.N(N2), .ENTRY_SIZE(E2), .RESENTRY_SIZE(R2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .matrixA(matrixA2), .matrixB(matrixB2),
    .busy(busy2), .done(done2), .matrixC(matrixC2));

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] pack_in(input mat_t m);
    logic [AW-1:0] f;
    f = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        f[((N*N-1)-(r*N+c))*E +: E] = E'(m[r][c]);
    return f;
  endfunction

  function automatic logic [CW-1:0] pack_c(input mat_t m);
    logic [CW-1:0] f;
    f = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        f[((N*N-1)-(r*N+c))*R +: R] = R'(m[r][c]);
    return f;
  endfunction

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], with B[k][j] held in slot s[j][k].
  function automatic logic [CW-1:0] model(input mat_t a, input mat_t s);
    mat_t c;
    int   sum;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum += a[i][k] * s[j][k];
`ifdef MATMUL_SAT_EN
        c[i][j] = (sum > (1 << R) - 1) ? (1 << R) - 1 : sum;
`else
        c[i][j] = sum % (1 << R);
`endif
      end
    return pack_c(c);
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        check("result", matrixC, sb.pop_front());
      end
    end
    if (!reset && done2) begin
      if (sb2.size() == 0) begin
        check("unexpected_done2", 1'b1, 1'b0);
      end else begin
        check("result_n2", matrixC2, sb2.pop_front());
      end
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 200);
  endtask

  task automatic run_one(input vec_t v, input string name);
    int cyc;
    @(negedge clk);
    matrixA = v.a; matrixB = v.b; start = 1'b1;
    sb.push_back(v.c);
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, busy, 1'b1);
    wait_done(cyc);
    check({name, "_latency"}, cyc, LAT);
    @(negedge clk);
    check({name, "_pulse_end"}, {busy, done}, 2'b00);
  endtask

  initial begin
    mat_t ma, ms, mc;
    int   cyc, base;

    // Vector table.
    ma = '{'{1,0,0},'{0,1,0},'{0,0,1}};
    ms = '{'{1,2,3},'{4,5,6},'{7,8,9}};
    mc = '{'{1,4,7},'{2,5,8},'{3,6,9}};
    tbl[0] = '{pack_in(ma), pack_in(ms), pack_c(mc)};
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
      ma[r][c] = 31; ms[r][c] = 31; mc[r][c] = EXP31;
    end
    tbl[1] = '{pack_in(ma), pack_in(ms), pack_c(mc)};
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
      ma[r][c] = 0; ms[r][c] = int'($urandom_range(0, 31)); mc[r][c] = 0;
    end
    tbl[2] = '{pack_in(ma), pack_in(ms), pack_c(mc)};
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
      ma[r][c] = 1; ms[r][c] = 2; mc[r][c] = 6;
    end
    tbl[3] = '{pack_in(ma), pack_in(ms), pack_c(mc)};
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
      ma[r][c] = int'($urandom_range(0, 31)); ms[r][c] = int'($urandom_range(0, 31));
    end
    tbl[4] = '{pack_in(ma), pack_in(ms), model(ma, ms)};

    // Reset state.
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    matrixA = '0; matrixB = '0; matrixA2 = '0; matrixB2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_matrixC", matrixC, '0);
    check("reset_matrixC2", matrixC2, '0);

    // Start on the first edge after reset deasserts.
    reset = 1'b0; start = 1'b1;
    matrixA = tbl[0].a; matrixB = tbl[0].b;
    sb.push_back(tbl[0].c);
    @(negedge clk);
    start = 1'b0;
    check("accept_after_reset", busy, 1'b1);
    wait_done(cyc);
    check("accept_after_reset_latency", cyc, LAT);

    // Table-driven vectors.
    for (int t = 0; t < 5; t++) run_one(tbl[t], $sformatf("vec%0d", t));

    // Second start 5 cycles into CALC with changed inputs is ignored.
    base = done_cnt;
    @(negedge clk);
    matrixA = tbl[4].a; matrixB = tbl[4].b; start = 1'b1;
    sb.push_back(tbl[4].c);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        matrixA = tbl[1].a; matrixB = tbl[1].b; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end while (!done && cyc < 200);
    check("restart_ignored_latency", cyc, LAT);
    repeat (40) @(negedge clk);
    check("restart_single_done", done_cnt - base, 1);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    check("reset_beats_start", busy, 1'b0);
    reset = 1'b0; start = 1'b0;

    // Reset at CALC cycle 10 aborts the run.
    @(negedge clk);
    matrixA = tbl[3].a; matrixB = tbl[3].b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_matrixC", matrixC, '0);
    reset = 1'b0;
    base = done_cnt;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - base, 0);

    // Start held high: back-to-back runs with one IDLE cycle between.
    @(negedge clk);
    matrixA = tbl[4].a; matrixB = tbl[4].b; start = 1'b1;
    sb.push_back(tbl[4].c);
    sb.push_back(tbl[4].c);
    @(negedge clk);
    wait_done(cyc);
    check("b2b_first_latency", cyc, LAT);
    @(negedge clk);
    check("b2b_idle_gap", {busy, done}, 2'b00);
    @(negedge clk);
    start = 1'b0;
    check("b2b_restart_busy", busy, 1'b1);
    wait_done(cyc);
    check("b2b_second_latency", cyc, LAT);
    @(negedge clk);
    check("b2b_pulse_end", {busy, done}, 2'b00);

    // N=2 instance.
    @(negedge clk);
    matrixA2 = {4'd1, 4'd2, 4'd3, 4'd4};
    matrixB2 = {4'd5, 4'd7, 4'd6, 4'd8};
    start2 = 1'b1;
    sb2.push_back({9'd19, 9'd22, 9'd43, 9'd50});
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done2 && cyc < 200);
    check("n2_latency", cyc, N2*N2*N2 + 1);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    check("scoreboard2_empty", sb2.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/matrix_mac_nxn.md
MATRIX_MAC_NXN -- requirements
Module: matrix_mac_nxn

Interface
REQ-001 SHALL have parameter N, default 3: matrix dimension; legal range 2..8.
REQ-002 SHALL have parameter ENTRY_SIZE, default 5: unsigned input entry width.
REQ-003 SHALL have parameter RESENTRY_SIZE, default 9: unsigned result entry width.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request a multiply; sampled only in IDLE.
REQ-007 SHALL have port matrixA, input, N*N*ENTRY_SIZE: A row-major; A[0][0] in MSBs.
REQ-008 SHALL have port matrixB, input, N*N*ENTRY_SIZE: B supplied column-wise; slot [j][k] holds B[k][j]; slot [0][0] in MSBs.
REQ-009 SHALL have port busy, output, 1: high in CALC.
REQ-010 SHALL have port done, output, 1: one-cycle pulse, result valid.
REQ-011 SHALL have port matrixC, output, N*N*RESENTRY_SIZE: C row-major; C[0][0] in MSBs.

Function
REQ-012 SHALL compute C[i][j] = sum over k of A[i][k]*B[k][j], unsigned.
REQ-013 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on start; CALC->DONE after last MAC; DONE->IDLE unconditionally.
REQ-014 SHALL capture matrixA and matrixB on the edge that accepts start; later input changes SHALL NOT affect the result.
REQ-015 SHALL perform exactly one multiply-accumulate per CALC cycle, with k innermost, then j, then i.
REQ-016 SHALL write C[i][j] into matrixC on the cycle its k=N-1 product is accumulated, then clear the accumulator.
REQ-017 SHALL assert done exactly N*N*N+1 edges after the start-accepting edge, for one cycle (DONE state).
REQ-018 SHALL hold matrixC stable from DONE until the next accepted start; entries are not cleared at start.
REQ-019 SHALL ignore start while in CALC or DONE; no queueing.
REQ-020 SHALL size the internal accumulator to 2*ENTRY_SIZE+clog2(N) bits; no internal overflow.
REQ-021 SHALL reduce each final sum to RESENTRY_SIZE bits per REQ-026/027.

Reset
REQ-022 SHALL on reset force IDLE, busy=0, done=0, matrixC=0, counters=0, accumulator=0.
REQ-023 SHALL let reset win over start in the same cycle; reset mid-CALC SHALL abort with no done pulse.
REQ-024 SHALL accept start on the first edge after reset deasserts.

Configuration
REQ-025 SHALL compile saturation logic only when macro MATMUL_SAT_EN is defined.
REQ-026 With MATMUL_SAT_EN, a sum exceeding 2^RESENTRY_SIZE-1 SHALL be written as 2^RESENTRY_SIZE-1.
REQ-027 Without MATMUL_SAT_EN, the sum SHALL be written modulo 2^RESENTRY_SIZE (truncated LSBs).

Structure
REQ-028 SHALL take the state enum, the index-width function clog2, and state encodings from shared package matmul_pkg.
REQ-029 SHALL instantiate one sub-module mac_unit (registered multiply-add with synchronous clear); all other logic SHALL be in the top module.

Verification
REQ-030 N=3, A=I, B slots rows [1,2,3],[4,5,6],[7,8,9], start -> done at edge 28, C rows [1,4,7],[2,5,8],[3,6,9].
REQ-031 N=3, all entries 31 -> every C entry 323 without MATMUL_SAT_EN, 511 with it.
REQ-032 start pulsed again 5 cycles after acceptance, with inputs changed -> ignored, a single done, result from the original inputs.
REQ-033 reset asserted at CALC cycle 10 -> next edge busy=0, done=0, matrixC=0; no done for 40 cycles.
REQ-034 N=2, ENTRY_SIZE=4, RESENTRY_SIZE=9, A=[[1,2],[3,4]], B=[[5,6],[7,8]] (slots [5,7],[6,8]) -> done at edge 9, C=[[19,22],[43,50]].
REQ-035 start held high continuously -> runs back-to-back with one IDLE cycle between each done and the next busy.
